// File: rtl/vram_arbiter.sv
// rtl/vram_arbiter.sv - shares the SDRAM controller port between VDP, aux master and refresh
module vram_arbiter #(
    parameter int ADDR_W       = 23,
    parameter int REFRESH_INT  = 810,
    parameter int REFRESH_MAX  = 7,
    parameter int URGENT_CREDS = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              vdp_req,
    input  logic              vdp_wr,
    input  logic [ADDR_W-1:0] vdp_addr,
    input  logic [31:0]       vdp_wdata,
    input  logic [1:0]        vdp_wsize,
    output logic [31:0]       vdp_rdata,
    output logic              vdp_rvalid,
    output logic              vdp_overrun,
    input  logic              aux_req,
    input  logic              aux_wr,
    input  logic [ADDR_W-1:0] aux_addr,
    input  logic [31:0]       aux_wdata,
    input  logic [1:0]        aux_wsize,
    output logic              aux_gnt,
    output logic [31:0]       aux_rdata,
    output logic              aux_rvalid,
    output logic              mem_read,
    output logic              mem_write,
    output logic              mem_refresh,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_din32,
    output logic [1:0]        mem_wr_size,
    input  logic              mem_busy,
    input  logic [31:0]       mem_dout32,
    output logic              refresh_ovf
);

    localparam int TMR_W  = (REFRESH_INT > 1) ? $clog2(REFRESH_INT) : 1;
    localparam int CRED_W = $clog2(REFRESH_MAX + 1);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT_HI, S_WAIT_LO} state_t;
    typedef enum logic [1:0] {OWN_VDP, OWN_AUX, OWN_REF} owner_t;

    state_t            state;
    owner_t            owner;
    logic              op_wr;
    logic [1:0]        wait_cnt;

    logic              slot_full;
    logic              slot_wr;
    logic [ADDR_W-1:0] slot_addr;
    logic [31:0]       slot_wdata;
    logic [1:0]        slot_wsize;

    logic              aux_pend;
    logic [TMR_W-1:0]  timer;
    logic [CRED_W-1:0] credits;

    logic              issue_go;
    logic              vdp_issue;
    logic              aux_issue;
    logic              ref_issue;
    logic              wrap;

    assign issue_go  = (state == S_ISSUE) && !mem_busy;
    assign vdp_issue = issue_go && (owner == OWN_VDP);
    assign aux_issue = issue_go && (owner == OWN_AUX);
    assign ref_issue = issue_go && (owner == OWN_REF);
    assign wrap      = (timer == TMR_W'(REFRESH_INT - 1));

    // VDP one-deep pending slot; a request that finds it occupied is dropped and flagged
    always_ff @(posedge clk) begin
        if (reset) begin
            slot_full   <= 1'b0;
            slot_wr     <= 1'b0;
            slot_addr   <= '0;
            slot_wdata  <= '0;
            slot_wsize  <= '0;
            vdp_overrun <= 1'b0;
        end else begin
            if (vdp_issue) begin
                slot_full <= 1'b0;
            end
            if (vdp_req) begin
                if (slot_full) begin
                    vdp_overrun <= 1'b1;
                end else begin
                    slot_full  <= 1'b1;
                    slot_wr    <= vdp_wr;
                    slot_addr  <= vdp_addr;
                    slot_wdata <= vdp_wdata;
                    slot_wsize <= vdp_wsize;
                end
            end
        end
    end

    // aux request is registered so a VDP strobe arriving in the same cycle is seen first
    always_ff @(posedge clk) begin
        if (reset) begin
            aux_pend <= 1'b0;
        end else begin
            aux_pend <= aux_req && !aux_issue;
        end
    end

    // refresh interval timer and saturating credit counter; earn and spend together cancel
    always_ff @(posedge clk) begin
        if (reset) begin
            timer       <= '0;
            credits     <= '0;
            refresh_ovf <= 1'b0;
        end else begin
            timer <= wrap ? '0 : timer + 1'b1;
            if (wrap && !ref_issue) begin
                if (credits == CRED_W'(REFRESH_MAX)) begin
                    refresh_ovf <= 1'b1;
                end else begin
                    credits <= credits + 1'b1;
                end
            end else if (ref_issue && !wrap) begin
                credits <= credits - 1'b1;
            end
        end
    end

    // arbitration FSM with registered command strobes, grant and completion pulses
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_IDLE;
            owner       <= OWN_VDP;
            op_wr       <= 1'b0;
            wait_cnt    <= '0;
            mem_read    <= 1'b0;
            mem_write   <= 1'b0;
            mem_refresh <= 1'b0;
            mem_addr    <= '0;
            mem_din32   <= '0;
            mem_wr_size <= '0;
            aux_gnt     <= 1'b0;
            vdp_rdata   <= '0;
            vdp_rvalid  <= 1'b0;
            aux_rdata   <= '0;
            aux_rvalid  <= 1'b0;
        end else begin
            mem_read    <= 1'b0;
            mem_write   <= 1'b0;
            mem_refresh <= 1'b0;
            aux_gnt     <= 1'b0;
            vdp_rvalid  <= 1'b0;
            aux_rvalid  <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (slot_full) begin
                        owner <= OWN_VDP;
                        state <= S_ISSUE;
                    end else if (credits >= CRED_W'(URGENT_CREDS)) begin
                        owner <= OWN_REF;
                        state <= S_ISSUE;
                    end else if (aux_pend) begin
                        owner <= OWN_AUX;
                        state <= S_ISSUE;
                    end else if (credits != '0) begin
                        owner <= OWN_REF;
                        state <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (!mem_busy) begin
                        wait_cnt <= '0;
                        state    <= S_WAIT_HI;
                        case (owner)
                            OWN_VDP: begin
                                op_wr       <= slot_wr;
                                mem_read    <= !slot_wr;
                                mem_write   <= slot_wr;
                                mem_addr    <= slot_addr;
                                mem_din32   <= slot_wdata;
                                mem_wr_size <= slot_wsize;
                            end
                            OWN_AUX: begin
                                op_wr       <= aux_wr;
                                mem_read    <= !aux_wr;
                                mem_write   <= aux_wr;
                                mem_addr    <= aux_addr;
                                mem_din32   <= aux_wdata;
                                mem_wr_size <= aux_wsize;
                                aux_gnt     <= 1'b1;
                            end
                            default: begin
                                op_wr       <= 1'b0;
                                mem_refresh <= 1'b1;
                            end
                        endcase
                    end
                end
                S_WAIT_HI: begin
                    if (mem_busy) begin
                        state <= S_WAIT_LO;
                    end else if (wait_cnt == 2'd3) begin
                        state <= S_IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                default: begin
                    if (!mem_busy) begin
                        state <= S_IDLE;
                        if (owner == OWN_VDP && !op_wr) begin
                            vdp_rdata  <= mem_dout32;
                            vdp_rvalid <= 1'b1;
                        end else if (owner == OWN_AUX) begin
                            if (!op_wr) begin
                                aux_rdata <= mem_dout32;
                            end
                            aux_rvalid <= 1'b1;
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vram_arbiter.sv
// tb/tb_vram_arbiter.sv - directed self-checking bench for vram_arbiter
module tb_vram_arbiter;

    localparam int ADDR_W   = 23;
    localparam int RINT     = 64;
    localparam int BUSY_LEN = 6;

    logic              clk;
    logic              reset;
    logic              vdp_req;
    logic              vdp_wr;
    logic [ADDR_W-1:0] vdp_addr;
    logic [31:0]       vdp_wdata;
    logic [1:0]        vdp_wsize;
    logic [31:0]       vdp_rdata;
    logic              vdp_rvalid;
    logic              vdp_overrun;
    logic              aux_req;
    logic              aux_wr;
    logic [ADDR_W-1:0] aux_addr;
    logic [31:0]       aux_wdata;
    logic [1:0]        aux_wsize;
    logic              aux_gnt;
    logic [31:0]       aux_rdata;
    logic              aux_rvalid;
    logic              mem_read;
    logic              mem_write;
    logic              mem_refresh;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_din32;
    logic [1:0]        mem_wr_size;
    logic              mem_busy;
    logic [31:0]       mem_dout32;
    logic              refresh_ovf;

    vram_arbiter #(
        .ADDR_W(ADDR_W), .REFRESH_INT(RINT), .REFRESH_MAX(7), .URGENT_CREDS(2)
    ) dut (
        .clk(clk), .reset(reset),
        .vdp_req(vdp_req), .vdp_wr(vdp_wr), .vdp_addr(vdp_addr), .vdp_wdata(vdp_wdata),
        .vdp_wsize(vdp_wsize), .vdp_rdata(vdp_rdata), .vdp_rvalid(vdp_rvalid),
        .vdp_overrun(vdp_overrun),
        .aux_req(aux_req), .aux_wr(aux_wr), .aux_addr(aux_addr), .aux_wdata(aux_wdata),
        .aux_wsize(aux_wsize), .aux_gnt(aux_gnt), .aux_rdata(aux_rdata), .aux_rvalid(aux_rvalid),
        .mem_read(mem_read), .mem_write(mem_write), .mem_refresh(mem_refresh),
        .mem_addr(mem_addr), .mem_din32(mem_din32), .mem_wr_size(mem_wr_size),
        .mem_busy(mem_busy), .mem_dout32(mem_dout32), .refresh_ovf(refresh_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // memory controller model: busy from the cycle after a strobe for BUSY_LEN cycles
    logic              busy_r;
    logic              force_busy;
    logic [2:0]        mcnt;
    logic [ADDR_W-1:0] m_addr;
    logic              m_rd;

    assign mem_busy = busy_r | force_busy;

    function automatic logic [31:0] model_data(input logic [ADDR_W-1:0] a);
        return 32'hDEADBEEF ^ {9'd0, a ^ 23'h000123};
    endfunction

    initial begin
        busy_r     = 1'b0;
        mcnt       = '0;
        m_addr     = '0;
        m_rd       = 1'b0;
        mem_dout32 = '0;
    end

    always @(posedge clk) begin
        if (!mem_busy && (mem_read || mem_write || mem_refresh)) begin
            busy_r <= 1'b1;
            mcnt   <= 3'(BUSY_LEN - 1);
            m_addr <= mem_addr;
            m_rd   <= mem_read;
        end else if (busy_r) begin
            if (mcnt == 3'd0) begin
                busy_r <= 1'b0;
                if (m_rd) mem_dout32 <= model_data(m_addr);
            end else begin
                mcnt <= mcnt - 3'd1;
            end
        end
    end

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int n_rd     = 0;
    int n_wr     = 0;
    int n_ref    = 0;
    int n_gnt    = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (mem_read)    n_rd++;
        if (mem_write)   n_wr++;
        if (mem_refresh) n_ref++;
        if (aux_gnt)     n_gnt++;
    endtask

    task automatic do_reset();
        int n;
        reset      = 1'b1;
        vdp_req    = 1'b0;
        aux_req    = 1'b0;
        force_busy = 1'b0;
        tick();
        tick();
        n = 0;
        while (busy_r && n < 20) begin
            tick();
            n++;
        end
        reset = 1'b0;
        cyc   = 0;
        n_rd  = 0;
        n_wr  = 0;
        n_ref = 0;
        n_gnt = 0;
    endtask

    task automatic vdp_cmd(input logic wr, input logic [ADDR_W-1:0] a);
        vdp_req  = 1'b1;
        vdp_wr   = wr;
        vdp_addr = a;
    endtask

    initial begin
        int n;
        int first_ref;
        int gnt_mid;
        int next_kind;
        int rv_cnt;

        vdp_wr    = 1'b0;
        vdp_addr  = '0;
        vdp_wdata = 32'h0;
        vdp_wsize = 2'd0;
        aux_wr    = 1'b0;
        aux_addr  = '0;
        aux_wdata = 32'h0;
        aux_wsize = 2'd0;

        // reset state
        do_reset();
        check("rst_strobes", {mem_read, mem_write, mem_refresh, aux_gnt,
                              vdp_rvalid, aux_rvalid, vdp_overrun, refresh_ovf}, 8'h00);
        check("rst_addr", mem_addr, 0);
        check("rst_data", {mem_din32, vdp_rdata}, 0);

        // test 1: single VDP read, mem_read two edges after the request edge
        tick();
        vdp_cmd(1'b0, 23'h000123);
        tick();
        vdp_req = 1'b0;
        check("t1_rd_e0", mem_read, 1'b0);
        tick();
        check("t1_rd_e1", mem_read, 1'b0);
        tick();
        check("t1_rd_e2", mem_read, 1'b1);
        check("t1_addr", mem_addr, 23'h000123);
        n = 0;
        while (!vdp_rvalid && n < 30) begin
            tick();
            n++;
        end
        check("t1_rvalid_lat", n, 8);
        check("t1_rdata", vdp_rdata, 32'hDEADBEEF);
        tick();
        check("t1_rvalid_pulse", vdp_rvalid, 1'b0);

        // test 2: VDP and aux in the same cycle; VDP first, aux write afterwards
        do_reset();
        vdp_cmd(1'b0, 23'h000456);
        aux_req   = 1'b1;
        aux_wr    = 1'b1;
        aux_addr  = 23'h07ABCD;
        aux_wdata = 32'h12345678;
        aux_wsize = 2'b10;
        tick();
        vdp_req = 1'b0;
        tick();
        tick();
        check("t2_vdp_first", {mem_read, mem_write, aux_gnt}, 3'b100);
        check("t2_vdp_addr", mem_addr, 23'h000456);
        n = 0;
        while (!vdp_rvalid && n < 30) begin
            tick();
            n++;
        end
        check("t2_no_early_gnt", n_gnt, 0);
        check("t2_vdp_rdata", vdp_rdata, 32'hDEADBB9A);
        n = 0;
        while (!aux_gnt && n < 10) begin
            tick();
            n++;
        end
        aux_req = 1'b0;
        check("t2_gnt_lat", n, 2);
        check("t2_aux_wr", {mem_read, mem_write}, 2'b01);
        check("t2_aux_addr", mem_addr, 23'h07ABCD);
        check("t2_aux_din", {mem_din32, 30'd0, mem_wr_size}, {32'h12345678, 32'h2});
        n = 0;
        while (!aux_rvalid && n < 30) begin
            tick();
            n++;
        end
        check("t2_aux_rvalid_lat", n, 8);

        // test 3: second request held in slot, third overruns; both complete in order
        do_reset();
        vdp_cmd(1'b0, 23'h000200);
        tick();
        vdp_req = 1'b0;
        tick();
        tick();
        vdp_cmd(1'b0, 23'h000300);
        tick();
        check("t3_no_overrun_yet", vdp_overrun, 1'b0);
        vdp_cmd(1'b0, 23'h0003FF);
        tick();
        vdp_req = 1'b0;
        check("t3_overrun", vdp_overrun, 1'b1);
        n = 0;
        while (!vdp_rvalid && n < 30) begin
            tick();
            n++;
        end
        check("t3_rdata1", vdp_rdata, 32'hDEADBDCC);
        n = 0;
        while (!mem_read && n < 10) begin
            tick();
            n++;
        end
        check("t3_addr2", mem_addr, 23'h000300);
        n = 0;
        while (!vdp_rvalid && n < 30) begin
            tick();
            n++;
        end
        check("t3_rdata2", vdp_rdata, 32'hDEADBCCC);
        repeat (12) tick();
        check("t3_read_count", n_rd, 2);

        // test 3b: request arriving on the very edge the slot issues is dropped
        do_reset();
        vdp_cmd(1'b0, 23'h000010);
        tick();
        vdp_req = 1'b0;
        tick();
        vdp_cmd(1'b0, 23'h000020);
        tick();
        vdp_req = 1'b0;
        check("t3b_issue", {mem_read, vdp_overrun}, 2'b11);
        check("t3b_addr", mem_addr, 23'h000010);
        repeat (25) tick();
        check("t3b_read_count", n_rd, 1);

        // test 4: continuous aux reads; refresh only takes over at two credits
        do_reset();
        aux_req   = 1'b1;
        aux_wr    = 1'b0;
        aux_addr  = 23'h000ABC;
        first_ref = -1;
        gnt_mid   = 0;
        next_kind = 0;
        for (int i = 0; i < 220; i++) begin
            tick();
            if (aux_gnt && cyc > RINT && cyc <= 2 * RINT) gnt_mid++;
            if (first_ref >= 0 && next_kind == 0) begin
                if (aux_gnt) next_kind = 1;
                else if (mem_refresh) next_kind = 2;
            end
            if (mem_refresh && first_ref < 0) first_ref = cyc;
        end
        aux_req = 1'b0;
        check("t4_ref_window", (first_ref > 2 * RINT) && (first_ref <= 2 * RINT + 12), 1'b1);
        check("t4_aux_wins_one_credit", gnt_mid >= 4, 1'b1);
        check("t4_aux_after_ref", next_kind, 1);
        check("t4_gnt_is_read", n_gnt, n_rd);
        repeat (20) tick();

        // test 5: controller stuck busy; credits saturate, no strobes while stuck
        do_reset();
        force_busy = 1'b1;
        repeat (2000) tick();
        check("t5_no_strobes", n_rd + n_wr + n_ref, 0);
        check("t5_ovf", refresh_ovf, 1'b1);
        check("t5_credits_sat", dut.credits, 3'd7);
        force_busy = 1'b0;
        n = 0;
        while (!mem_refresh && n < 10) begin
            tick();
            n++;
        end
        check("t5_refresh_after_release", {mem_refresh, mem_read, mem_write}, 3'b100);
        repeat (30) tick();

        // test 6: reset during WAIT_LO of an aux read
        do_reset();
        check("t6_ovf_cleared", refresh_ovf, 1'b0);
        aux_req  = 1'b1;
        aux_wr   = 1'b0;
        aux_addr = 23'h000055;
        n = 0;
        while (!aux_gnt && n < 10) begin
            tick();
            n++;
        end
        check("t6_gnt_seen", aux_gnt, 1'b1);
        aux_req = 1'b0;
        tick();
        tick();
        check("t6_busy", mem_busy, 1'b1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("t6_outs_zero", {mem_read, mem_write, mem_refresh, aux_gnt,
                               vdp_rvalid, aux_rvalid, vdp_overrun, refresh_ovf}, 8'h00);
        check("t6_addr_zero", {mem_addr, aux_rdata}, 0);
        check("t6_credits", dut.credits, 3'd0);
        rv_cnt = 0;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (aux_rvalid || aux_gnt) rv_cnt++;
        end
        check("t6_no_rvalid", rv_cnt, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
